// File: rtl/tick_event_scheduler.sv
// -----------------------------------------------------------------------------
// tick_event_scheduler
//   Collects periodic event requests from the tick generators and serves them
//   one at a time onto the single shared transmitter. A rising tick sets a
//   pending flag. Pending flags are granted round-robin over a valid/ack
//   handshake. After each accepted grant the block waits for tx_done, with a
//   timeout. A source that ticks again before it was served raises a sticky
//   overrun flag.
//
// Ports
//   clk          in   1      system clock
//   rst          in   1      synchronous reset, active-high
//   tick         in   N_REQ  generator outputs; a rising edge of bit i requests source i
//   grant_valid  out  1      grant offered to the transmitter
//   grant_id     out  ID_W   source being granted; stable while grant_valid=1
//   grant_ack    in   1      transmitter accepts the grant (valid & ack)
//   tx_done      in   1      one-cycle pulse: current transmission finished
//   busy         out  1      1 while offering or waiting for tx_done
//   timeout_err  out  1      one-cycle pulse when the tx_done wait times out
//   overrun      out  N_REQ  sticky per-source overrun flags
//   overrun_clr  in   N_REQ  write-1-to-clear for the overrun flags
// -----------------------------------------------------------------------------
module tick_event_scheduler #(
    parameter int N_REQ   = 4,
    parameter int ID_W    = 2,
    parameter int TIMEOUT = 1000,
    parameter int CNT_W   = 10
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_REQ-1:0] tick,
    output logic             grant_valid,
    output logic [ID_W-1:0]  grant_id,
    input  logic             grant_ack,
    input  logic             tx_done,
    output logic             busy,
    output logic             timeout_err,
    output logic [N_REQ-1:0] overrun,
    input  logic [N_REQ-1:0] overrun_clr
);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        OFFER     = 2'd1,
        WAIT_DONE = 2'd2
    } state_t;

    state_t             state;
    logic [N_REQ-1:0]   tick_q;
    logic [N_REQ-1:0]   pending;
    logic [ID_W-1:0]    last_id;
    logic [CNT_W-1:0]   timer;

    logic [N_REQ-1:0]   rise;
    logic [N_REQ-1:0]   clr;
    logic [N_REQ-1:0]   pending_n;
    logic [N_REQ-1:0]   overrun_n;
    logic               handshake;
    logic [ID_W-1:0]    winner;

    // Round-robin pick: the pending source closest after 'last' (wrapping)
    // wins. Distance 0 is last+1, distance N_REQ-1 is last itself.
    function automatic logic [ID_W-1:0] rr_pick(input logic [N_REQ-1:0] req,
                                                 input logic [ID_W-1:0]  last);
        logic [ID_W-1:0] pick;
        int              best_d;
        int              d;
        pick   = '0;
        best_d = N_REQ;
        for (int i = 0; i < N_REQ; i++) begin
            d = (i - int'(last) - 1 + 2 * N_REQ) % N_REQ;
            if (req[i] && (d < best_d)) begin
                best_d = d;
                pick   = ID_W'(i);
            end
        end
        return pick;
    endfunction

    assign rise      = tick & ~tick_q;
    assign handshake = (state == OFFER) && grant_ack;
    assign winner    = rr_pick(pending, last_id);

    always_comb begin
        clr = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (handshake && (grant_id == ID_W'(i))) begin
                clr[i] = 1'b1;
            end
        end
    end

    // A new rise wins over the clear of the same source, and a rise on a
    // source whose request is being served in this very cycle is not an
    // overrun: the new request simply becomes the next pending one.
    assign pending_n = (pending & ~clr) | rise;
    assign overrun_n = (overrun & ~overrun_clr) | (rise & pending & ~clr);

    always_ff @(posedge clk) begin
        // tick_q follows tick even during reset, so a tick that is already
        // high when reset releases is not seen as a rising edge.
        tick_q      <= tick;
        timeout_err <= 1'b0;
        if (rst) begin
            pending     <= '0;
            overrun     <= '0;
            state       <= IDLE;
            last_id     <= ID_W'(N_REQ - 1);
            timer       <= '0;
            grant_valid <= 1'b0;
            grant_id    <= '0;
            busy        <= 1'b0;
        end else begin
            pending <= pending_n;
            overrun <= overrun_n;
            case (state)
                IDLE: begin
                    if (|pending) begin
                        grant_id    <= winner;
                        grant_valid <= 1'b1;
                        busy        <= 1'b1;
                        state       <= OFFER;
                    end
                end
                OFFER: begin
                    // grant_id is frozen here; late requests wait their turn.
                    if (grant_ack) begin
                        grant_valid <= 1'b0;
                        last_id     <= grant_id;
                        timer       <= '0;
                        state       <= WAIT_DONE;
                    end
                end
                WAIT_DONE: begin
                    timer <= timer + CNT_W'(1);
                    if (tx_done) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end else if (timer == CNT_W'(TIMEOUT - 1)) begin
                        timeout_err <= 1'b1;
                        state       <= IDLE;
                        busy        <= 1'b0;
                    end
                end
                default: begin
                    state       <= IDLE;
                    busy        <= 1'b0;
                    grant_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_tick_event_scheduler.sv
// -----------------------------------------------------------------------------
// tb_tick_event_scheduler
//   Directed bench for tick_event_scheduler. Inputs change 1 ns after the
//   rising clock edge and outputs are checked at that same point, well away
//   from the next active edge. Expected values are hand-derived constants.
// -----------------------------------------------------------------------------
module tb_tick_event_scheduler;

    localparam int N_REQ   = 4;
    localparam int ID_W    = 2;
    localparam int TIMEOUT = 16;
    localparam int CNT_W   = 5;

    logic             clk;
    logic             rst;
    logic [N_REQ-1:0] tick;
    logic             grant_valid;
    logic [ID_W-1:0]  grant_id;
    logic             grant_ack;
    logic             tx_done;
    logic             busy;
    logic             timeout_err;
    logic [N_REQ-1:0] overrun;
    logic [N_REQ-1:0] overrun_clr;

    int tests_run;
    int tests_failed;

    tick_event_scheduler #(
        .N_REQ  (N_REQ),
        .ID_W   (ID_W),
        .TIMEOUT(TIMEOUT),
        .CNT_W  (CNT_W)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .tick       (tick),
        .grant_valid(grant_valid),
        .grant_id   (grant_id),
        .grant_ack  (grant_ack),
        .tx_done    (tx_done),
        .busy       (busy),
        .timeout_err(timeout_err),
        .overrun    (overrun),
        .overrun_clr(overrun_clr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_reset;
        rst = 1'b1;
        tick = 4'b0001;
        cyc(2);
        rst = 1'b0;
        tests_run++;
        if ({grant_valid, grant_id, busy, timeout_err, overrun} !== 9'b0) begin
            tests_failed++;
            $display("FAIL reset_outputs: got gv=%0b id=%0d busy=%0b to=%0b ovr=%b, expected all 0",
                     grant_valid, grant_id, busy, timeout_err, overrun);
        end
        cyc(3);
        tests_run++;
        if ({grant_valid, dut.pending} !== 5'b0) begin
            tests_failed++;
            $display("FAIL reset_tick_high: got gv=%0b pending=%b, expected gv=0 pending=0000",
                     grant_valid, dut.pending);
        end
        tick = 4'b0000;
        cyc(1);
    endtask

    task automatic test_single;
        tick = 4'b0010;
        cyc(1);
        tests_run++;
        if (dut.pending !== 4'b0010 || grant_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL single_pending: got pending=%b gv=%0b, expected 0010 gv=0", dut.pending, grant_valid);
        end
        cyc(1);
        tests_run++;
        if (grant_valid !== 1'b1 || grant_id !== 2'd1 || busy !== 1'b1) begin
            tests_failed++;
            $display("FAIL single_grant: got gv=%0b id=%0d busy=%0b, expected gv=1 id=1 busy=1", grant_valid, grant_id, busy);
        end
        grant_ack = 1'b1;
        tick = 4'b0000;
        cyc(1);
        grant_ack = 1'b0;
        tests_run++;
        if (grant_valid !== 1'b0 || busy !== 1'b1 || dut.pending !== 4'b0000) begin
            tests_failed++;
            $display("FAIL single_ack: got gv=%0b busy=%0b pending=%b, expected gv=0 busy=1 pending=0000",
                     grant_valid, busy, dut.pending);
        end
        cyc(2);
        tx_done = 1'b1;
        cyc(1);
        tx_done = 1'b0;
        tests_run++;
        if (busy !== 1'b0 || timeout_err !== 1'b0) begin
            tests_failed++;
            $display("FAIL single_done: got busy=%0b to=%0b, expected busy=0 to=0", busy, timeout_err);
        end
    endtask

    task automatic test_fairness;
        logic [ID_W-1:0] exp_id;
        rst = 1'b1;
        cyc(1);
        rst = 1'b0;
        tick = 4'b1111;
        cyc(1);
        tick = 4'b0000;
        cyc(1);
        for (int k = 0; k < N_REQ; k++) begin
            exp_id = ID_W'(k);
            tests_run++;
            if (grant_valid !== 1'b1 || grant_id !== exp_id) begin
                tests_failed++;
                $display("FAIL fair_order_%0d: got gv=%0b id=%0d, expected gv=1 id=%0d", k, grant_valid, grant_id, exp_id);
            end
            grant_ack = 1'b1;
            cyc(1);
            grant_ack = 1'b0;
            tx_done = 1'b1;
            cyc(1);
            tx_done = 1'b0;
            tests_run++;
            if (grant_valid !== 1'b0 || busy !== 1'b0) begin
                tests_failed++;
                $display("FAIL fair_idle_gap_%0d: got gv=%0b busy=%0b, expected gv=0 busy=0", k, grant_valid, busy);
            end
            cyc(1);
        end
        // Second round: sources 3 and 0 request; after last_id=3 source 0 wins.
        tick = 4'b1001;
        cyc(1);
        tick = 4'b0000;
        cyc(1);
        tests_run++;
        if (grant_valid !== 1'b1 || grant_id !== 2'd0) begin
            tests_failed++;
            $display("FAIL fair_wrap: got gv=%0b id=%0d, expected gv=1 id=0", grant_valid, grant_id);
        end
        grant_ack = 1'b1;
        cyc(1);
        grant_ack = 1'b0;
        tx_done = 1'b1;
        cyc(1);
        tx_done = 1'b0;
        cyc(1);
        tests_run++;
        if (grant_valid !== 1'b1 || grant_id !== 2'd3) begin
            tests_failed++;
            $display("FAIL fair_second: got gv=%0b id=%0d, expected gv=1 id=3", grant_valid, grant_id);
        end
        grant_ack = 1'b1;
        cyc(1);
        grant_ack = 1'b0;
        tx_done = 1'b1;
        cyc(1);
        tx_done = 1'b0;
        cyc(1);
    endtask

    task automatic test_overrun;
        tick = 4'b0100;
        cyc(1);
        tick = 4'b0000;
        cyc(1);
        tests_run++;
        if (grant_valid !== 1'b1 || grant_id !== 2'd2 || overrun !== 4'b0000) begin
            tests_failed++;
            $display("FAIL ovr_offer: got gv=%0b id=%0d ovr=%b, expected gv=1 id=2 ovr=0000", grant_valid, grant_id, overrun);
        end
        tick = 4'b1100;
        cyc(1);
        tick = 4'b0000;
        tests_run++;
        if (overrun !== 4'b0100 || grant_id !== 2'd2) begin
            tests_failed++;
            $display("FAIL ovr_set: got ovr=%b id=%0d, expected ovr=0100 id=2", overrun, grant_id);
        end
        cyc(1);
        tick = 4'b0100;
        cyc(1);
        tick = 4'b0000;
        cyc(2);
        tests_run++;
        if (overrun !== 4'b0100 || grant_valid !== 1'b1 || grant_id !== 2'd2) begin
            tests_failed++;
            $display("FAIL ovr_sticky: got ovr=%b gv=%0b id=%0d, expected ovr=0100 gv=1 id=2", overrun, grant_valid, grant_id);
        end
        overrun_clr = 4'b0100;
        cyc(1);
        overrun_clr = 4'b0000;
        tests_run++;
        if (overrun !== 4'b0000) begin
            tests_failed++;
            $display("FAIL ovr_clear: got ovr=%b, expected 0000", overrun);
        end
        grant_ack = 1'b1;
        cyc(1);
        grant_ack = 1'b0;
        tests_run++;
        if (dut.pending !== 4'b1000) begin
            tests_failed++;
            $display("FAIL ovr_pending_after_ack: got pending=%b, expected 1000", dut.pending);
        end
        tx_done = 1'b1;
        cyc(1);
        tx_done = 1'b0;
        cyc(1);
        tests_run++;
        if (grant_valid !== 1'b1 || grant_id !== 2'd3) begin
            tests_failed++;
            $display("FAIL ovr_next_grant: got gv=%0b id=%0d, expected gv=1 id=3", grant_valid, grant_id);
        end
        grant_ack = 1'b1;
        cyc(1);
        grant_ack = 1'b0;
        tx_done = 1'b1;
        cyc(1);
        tx_done = 1'b0;
        cyc(1);
    endtask

    task automatic test_timeout;
        int early;
        tick = 4'b0001;
        cyc(1);
        tick = 4'b0000;
        cyc(1);
        grant_ack = 1'b1;
        cyc(1);
        grant_ack = 1'b0;
        early = 0;
        for (int k = 1; k < TIMEOUT; k++) begin
            cyc(1);
            if (timeout_err !== 1'b0 || busy !== 1'b1) early++;
        end
        tests_run++;
        if (early !== 0) begin
            tests_failed++;
            $display("FAIL to_early: got %0d cycles with to=1 or busy=0 before the limit, expected 0", early);
        end
        cyc(1);
        tests_run++;
        if (timeout_err !== 1'b1 || busy !== 1'b0) begin
            tests_failed++;
            $display("FAIL to_pulse: got to=%0b busy=%0b, expected to=1 busy=0", timeout_err, busy);
        end
        cyc(1);
        tests_run++;
        if (timeout_err !== 1'b0 || busy !== 1'b0) begin
            tests_failed++;
            $display("FAIL to_one_cycle: got to=%0b busy=%0b, expected to=0 busy=0", timeout_err, busy);
        end
    endtask

    task automatic test_collisions;
        tick = 4'b0001;
        cyc(1);
        tick = 4'b0000;
        cyc(1);
        grant_ack = 1'b1;
        tick = 4'b0001;
        cyc(1);
        grant_ack = 1'b0;
        tick = 4'b0000;
        tests_run++;
        if (dut.pending !== 4'b0001 || overrun !== 4'b0000) begin
            tests_failed++;
            $display("FAIL coll_rise_ack: got pending=%b ovr=%b, expected pending=0001 ovr=0000", dut.pending, overrun);
        end
        tx_done = 1'b1;
        cyc(1);
        tx_done = 1'b0;
        cyc(1);
        tests_run++;
        if (grant_valid !== 1'b1 || grant_id !== 2'd0) begin
            tests_failed++;
            $display("FAIL coll_regrant: got gv=%0b id=%0d, expected gv=1 id=0", grant_valid, grant_id);
        end
        grant_ack = 1'b1;
        cyc(1);
        grant_ack = 1'b0;
        cyc(TIMEOUT - 1);
        tests_run++;
        if (busy !== 1'b1) begin
            tests_failed++;
            $display("FAIL coll_still_waiting: got busy=%0b, expected 1", busy);
        end
        tx_done = 1'b1;
        cyc(1);
        tx_done = 1'b0;
        tests_run++;
        if (timeout_err !== 1'b0 || busy !== 1'b0) begin
            tests_failed++;
            $display("FAIL coll_done_at_limit: got to=%0b busy=%0b, expected to=0 busy=0", timeout_err, busy);
        end
        cyc(1);
    endtask

    task automatic test_reset_mid;
        tick = 4'b0010;
        cyc(1);
        tick = 4'b0000;
        cyc(1);
        tick = 4'b0010;
        cyc(1);
        tick = 4'b0000;
        tests_run++;
        if (grant_valid !== 1'b1 || grant_id !== 2'd1 || overrun !== 4'b0010) begin
            tests_failed++;
            $display("FAIL mid_setup: got gv=%0b id=%0d ovr=%b, expected gv=1 id=1 ovr=0010", grant_valid, grant_id, overrun);
        end
        rst = 1'b1;
        cyc(1);
        rst = 1'b0;
        tests_run++;
        if (grant_valid !== 1'b0 || busy !== 1'b0 || dut.pending !== 4'b0000 || overrun !== 4'b0000) begin
            tests_failed++;
            $display("FAIL mid_reset: got gv=%0b busy=%0b pending=%b ovr=%b, expected all 0",
                     grant_valid, busy, dut.pending, overrun);
        end
        tick = 4'b1000;
        cyc(1);
        tick = 4'b0000;
        cyc(1);
        tests_run++;
        if (grant_valid !== 1'b1 || grant_id !== 2'd3) begin
            tests_failed++;
            $display("FAIL mid_fresh_grant: got gv=%0b id=%0d, expected gv=1 id=3", grant_valid, grant_id);
        end
        grant_ack = 1'b1;
        cyc(1);
        grant_ack = 1'b0;
        tx_done = 1'b1;
        cyc(1);
        tx_done = 1'b0;
        tests_run++;
        if (busy !== 1'b0 || timeout_err !== 1'b0) begin
            tests_failed++;
            $display("FAIL mid_fresh_done: got busy=%0b to=%0b, expected busy=0 to=0", busy, timeout_err);
        end
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        rst          = 1'b1;
        tick         = '0;
        grant_ack    = 1'b0;
        tx_done      = 1'b0;
        overrun_clr  = '0;
        #1;
        test_reset();
        test_single();
        test_fairness();
        test_overrun();
        test_timeout();
        test_collisions();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
